cell_comm_tx_arbiter: RTL
=========================

// Module: cell_comm_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one Aurora cell-comm TX AXIS link (CCW or CW) between
//  two sources: locally generated FA packets (src 0) and packets forwarded from the opposite RX link
//  (src 1). Runs in the link's Aurora user clock domain. Gates traffic on channel-up, discards while
//  the link is down, and truncates over-length packets so a stuck source cannot hold the link.
// PARAMETERS
//  DATA_WIDTH  32   AXIS tdata width (matches Aurora TX)
//  MAX_WORDS   64   max beats per packet; beat MAX_WORDS without tlast is forced last
//  CNT_WIDTH   16   width of status counters
// PORTS
//  auroraUserClk    in   1            Aurora user clock; only clock
//  auroraUserReset  in   1            synchronous, active-high reset
//  channelUp        in   1            Aurora channel-up status of the shared link
//  s0Tvalid/s1Tvalid in  1            source 0 (local) / 1 (forward) valid
//  s0Tlast/s1Tlast  in   1            source last beat
//  s0Tdata/s1Tdata  in   DATA_WIDTH   source data
//  s0Tready/s1Tready out 1            source ready
//  mTvalid          out  1            to Aurora axiTxTvalid
//  mTlast           out  1            to Aurora axiTxTlast
//  mTdata           out  DATA_WIDTH   to Aurora axiTxTdata
//  mTready          in   1            from Aurora axiTxTready
//  grant            out  1            current/last granted source index
//  pktCount0/1      out  CNT_WIDTH    packets fully sent per source (wraps)
//  dropCount        out  CNT_WIDTH    packets (whole or partial) discarded due to channel down
//  truncCount       out  CNT_WIDTH    packets truncated at MAX_WORDS
// BEHAVIOUR
//  - Reset: state IDLE, grant=0, priority pointer=0 (src 0 favoured), beat counter 0, all counters 0,
//    mTvalid=mTlast=0, s0Tready=s1Tready=0. Reset mid-packet abandons packet; no tlast emitted.
//  - States: IDLE, PASS, DISCARD.
//  - IDLE: all treadys 0, mTvalid 0. If channelUp=0 and any source valid: grant that source (pointer
//    rule), go DISCARD, count drop. If channelUp=1 and any valid: grant registered; both valid ->
//    source at priority pointer; go PASS. One-cycle arbitration bubble between packets.
//  - PASS: combinational pass-through of granted source: mTvalid=sXTvalid, mTdata=sXTdata,
//    sXTready=mTready, mTlast=sXTlast | (beat==MAX_WORDS-1). Ungranted tready=0. Beat counter
//    increments on each handshake (mTvalid&mTready).
//    * handshake with sXTlast: pktCount[X]++, pointer<=~X, beat<=0, ->IDLE.
//    * handshake at beat MAX_WORDS-1 without sXTlast: forced mTlast, truncCount++, pointer<=~X,
//      beat<=0, ->DISCARD (rest of input packet swallowed).
//    * channelUp falls (sampled): mTvalid forced 0 from that cycle, dropCount++, ->DISCARD.
//      Both forced-last and channel-down in same cycle: channel-down wins (no handshake counted).
//  - DISCARD: mTvalid=0; granted sXTready=1; on sXTvalid&sXTlast -> IDLE, pointer<=~X. No counters
//    change beyond the entry increment. Other source stays stalled.
//  - Single-beat packets (tlast on first beat) valid; counted as one packet.
//  - Counters wrap at 2**CNT_WIDTH-1 -> 0. grant holds value in IDLE.
//  - mTvalid never asserted when channelUp=0 in the same cycle's sampled state; mTdata don't-care
//    when mTvalid=0 (driven 0 for debug cleanliness).
// TESTING
//  1 Reset, channelUp=1, src0 sends 4-beat pkt, mTready=1 -> 4 beats out, mTlast on beat 4,
//    pktCount0=1, grant=0, src1 tready stays 0.
//  2 Both sources hold 3-beat pkts continuously -> output alternates 0,1,0,1 with 1 idle cycle
//    between packets; after 4 pkts pktCount0=pktCount1=2.
//  3 src1 sends 70 beats, MAX_WORDS=64 -> beat 64 has mTlast=1, truncCount=1, remaining 6 beats
//    accepted with mTvalid=0, then src0 packet granted.
//  4 channelUp=0, src0 sends 5-beat pkt -> s0Tready=1 throughout, mTvalid=0, dropCount=1.
//  5 channelUp drops after beat 2 of 8-beat pkt -> mTvalid=0 from next cycle, dropCount=1,
//    beats 3..8 swallowed, pktCount unchanged; channelUp restored -> next pkt passes cleanly.
//  6 mTready toggled 1/0 randomly during 10-beat pkt -> all 10 beats delivered in order, no
//    duplication; reset asserted mid-pkt -> all outputs/counters 0 next cycle.

Source files
------------

// File: rtl/cell_comm_tx_arbiter.sv
// ---------------------------------------------------------------------------
// cell_comm_tx_arbiter
//
// Shares one Aurora cell-comm TX AXI-Stream link between two packet sources:
// locally generated FA packets (source 0) and packets forwarded from the
// opposite RX link (source 1). Arbitration is packet-granular round robin,
// with a one-cycle arbitration bubble in IDLE between packets. While the link
// is down, traffic is swallowed instead of sent. Any packet that reaches
// MAX_WORDS beats without tlast is cut short, so a stuck source cannot hold
// the link.
//
// Ports
//   auroraUserClk     Aurora user clock; the only clock
//   auroraUserReset   synchronous, active-high reset
//   channelUp         Aurora channel-up status of the shared link
//   s0T* / s1T*       AXIS slave ports for source 0 (local) and 1 (forward)
//   mT*               AXIS master port towards the Aurora TX user interface
//   grant             current or most recently granted source index
//   pktCount0/1       packets fully sent per source (wrapping)
//   dropCount         packets, whole or partial, discarded due to link down
//   truncCount        packets truncated at MAX_WORDS beats
// ---------------------------------------------------------------------------
module cell_comm_tx_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  auroraUserClk,
  input  logic                  auroraUserReset,
  input  logic                  channelUp,
  input  logic                  s0Tvalid,
  input  logic                  s0Tlast,
  input  logic [DATA_WIDTH-1:0] s0Tdata,
  output logic                  s0Tready,
  input  logic                  s1Tvalid,
  input  logic                  s1Tlast,
  input  logic [DATA_WIDTH-1:0] s1Tdata,
  output logic                  s1Tready,
  output logic                  mTvalid,
  output logic                  mTlast,
  output logic [DATA_WIDTH-1:0] mTdata,
  input  logic                  mTready,
  output logic                  grant,
  output logic [CNT_WIDTH-1:0]  pktCount0,
  output logic [CNT_WIDTH-1:0]  pktCount1,
  output logic [CNT_WIDTH-1:0]  dropCount,
  output logic [CNT_WIDTH-1:0]  truncCount
);

  localparam int BEAT_WIDTH = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS    = 2'd1,
    DISCARD = 2'd2
  } arbState_t;

  arbState_t             state;
  logic                  pointer;
  logic [BEAT_WIDTH-1:0] beat;

  logic                  selValid;
  logic                  selLast;
  logic [DATA_WIDTH-1:0] selData;
  logic                  selReady;
  logic                  anyValid;
  logic                  pick;
  logic                  atLimit;
  logic                  handshake;

  // View of whichever source currently holds the grant.
  always_comb begin
    selValid = grant ? s1Tvalid : s0Tvalid;
    selLast  = grant ? s1Tlast  : s0Tlast;
    selData  = grant ? s1Tdata  : s0Tdata;
  end

  // When both sources want the link, the priority pointer decides;
  // otherwise whichever one is valid wins.
  assign anyValid = s0Tvalid | s1Tvalid;
  assign pick     = (s0Tvalid & s1Tvalid) ? pointer : s1Tvalid;
  assign atLimit  = (beat == LAST_BEAT);

  // Datapath steering. PASS is a combinational pass-through that is
  // suppressed the moment channelUp drops. The source is stalled in that
  // cycle as well, so no beat leaves it without also reaching the link.
  // DISCARD drains the granted source with tready held high.
  always_comb begin
    mTvalid  = 1'b0;
    mTlast   = 1'b0;
    mTdata   = '0;
    selReady = 1'b0;
    case (state)
      PASS: begin
        if (channelUp) begin
          mTvalid  = selValid;
          mTlast   = selValid & (selLast | atLimit);
          mTdata   = selValid ? selData : '0;
          selReady = mTready;
        end
      end
      DISCARD: selReady = 1'b1;
      default: selReady = 1'b0;
    endcase
    s0Tready = selReady & ~grant;
    s1Tready = selReady & grant;
  end

  assign handshake = mTvalid & mTready;

  // Arbitration state machine, beat counter and status counters. A
  // channel-down event in PASS takes precedence over a forced last, because
  // mTvalid is already gated off in that cycle.
  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      pointer    <= 1'b0;
      beat       <= '0;
      pktCount0  <= '0;
      pktCount1  <= '0;
      dropCount  <= '0;
      truncCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (anyValid) begin
            grant <= pick;
            if (channelUp) begin
              state <= PASS;
            end else begin
              state     <= DISCARD;
              dropCount <= dropCount + CNT_WIDTH'(1);
            end
          end
        end

        PASS: begin
          if (!channelUp) begin
            state     <= DISCARD;
            beat      <= '0;
            dropCount <= dropCount + CNT_WIDTH'(1);
          end else if (handshake) begin
            if (selLast) begin
              if (grant) pktCount1 <= pktCount1 + CNT_WIDTH'(1);
              else       pktCount0 <= pktCount0 + CNT_WIDTH'(1);
              pointer <= ~grant;
              beat    <= '0;
              state   <= IDLE;
            end else if (atLimit) begin
              truncCount <= truncCount + CNT_WIDTH'(1);
              pointer    <= ~grant;
              beat       <= '0;
              state      <= DISCARD;
            end else begin
              beat <= beat + BEAT_WIDTH'(1);
            end
          end
        end

        DISCARD: begin
          if (selValid && selLast) begin
            pointer <= ~grant;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
